// File: rtl/multicycle_control_unit.sv
// -----------------------------------------------------------------------------
// multicycle_control_unit
//
// Multi-cycle sequencer for the shared-memory RISC-V datapath. Each
// instruction walks through fetch, decode, execute, memory and writeback
// states. The memory-ready handshake stalls FETCH, MEMRD and MEMWR. Datapath
// strobes and mux selects come from a Moore decode of the registered state.
// The one exception is pcwrite/irwrite in FETCH, which follow mem_ready_i so
// that the PC and IR are loaded exactly once per instruction.
//
// Parameters
//   ENABLE_ITYPE    : 1 = decode OP-IMM (0010011), 0 = treat it as illegal
//   HALT_ON_ILLEGAL : 1 = TRAP holds until reset, 0 = TRAP lasts one cycle
//   CNT_W           : width of the retired-instruction counter
//
// Ports
//   clk_i          : clock, rising edge
//   rst_i          : synchronous active-high reset
//   instruction_i  : opcode field ir[6:0]
//   mem_ready_i    : memory has completed the current access
//   pcwrite_o      : load PC
//   irwrite_o      : load IR
//   iord_o         : memory address source (0 = PC, 1 = ALU result register)
//   memread_o      : memory read request
//   memwrite_o     : memory write request
//   regwrite_o     : register file write enable
//   memtoreg_o     : writeback source (1 = memory data register)
//   alusrca_o      : ALU A select (00 = PC, 01 = rs1, 10 = oldPC)
//   alusrcb_o      : ALU B select (00 = rs2, 01 = const 4, 10 = immediate)
//   aluop_o        : 00 = add, 01 = subtract/compare, 10 = funct decode
//   branch_o       : load PC if the ALU zero flag is set
//   illegal_o      : high while in TRAP
//   instret_o      : retired-instruction count, wraps silently
// -----------------------------------------------------------------------------
module multicycle_control_unit #(
  parameter bit          ENABLE_ITYPE    = 1'b1,
  parameter bit          HALT_ON_ILLEGAL = 1'b1,
  parameter int unsigned CNT_W           = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [6:0]       instruction_i,
  input  logic             mem_ready_i,
  output logic             pcwrite_o,
  output logic             irwrite_o,
  output logic             iord_o,
  output logic             memread_o,
  output logic             memwrite_o,
  output logic             regwrite_o,
  output logic             memtoreg_o,
  output logic [1:0]       alusrca_o,
  output logic [1:0]       alusrcb_o,
  output logic [1:0]       aluop_o,
  output logic             branch_o,
  output logic             illegal_o,
  output logic [CNT_W-1:0] instret_o
);

  // Opcodes recognised by the decoder
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // ALU A select encodings
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_RS1   = 2'b01;
  localparam logic [1:0] SRCA_OLDPC = 2'b10;

  // ALU B select encodings
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  // ALU operation encodings
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMRD,
    MEMWB,
    MEMWR,
    EXECR,
    EXECI,
    ALUWB,
    BEQ,
    TRAP
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             retire;

  // State and retired-instruction counter registers. Reset wins over every
  // transition, including a pending retire out of MEMWR.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= FETCH;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  // Next-state logic. The retire flag marks the last cycle of every
  // completed instruction. TRAP never retires.
  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    unique case (state_q)
      FETCH: begin
        if (mem_ready_i) state_d = DECODE;
      end
      DECODE: begin
        unique case (instruction_i)
          OP_LOAD,
          OP_STORE:  state_d = MEMADR;
          OP_REG:    state_d = EXECR;
          OP_BRANCH: state_d = BEQ;
          OP_IMM:    state_d = ENABLE_ITYPE ? EXECI : TRAP;
          default:   state_d = TRAP;
        endcase
      end
      MEMADR: begin
        // Only loads and stores reach MEMADR, so anything that is not a load
        // is handled as a store.
        state_d = (instruction_i == OP_LOAD) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        if (mem_ready_i) state_d = MEMWB;
      end
      MEMWB: begin
        state_d = FETCH;
        retire  = 1'b1;
      end
      MEMWR: begin
        if (mem_ready_i) begin
          state_d = FETCH;
          retire  = 1'b1;
        end
      end
      EXECR: begin
        state_d = ALUWB;
      end
      EXECI: begin
        state_d = ALUWB;
      end
      ALUWB: begin
        state_d = FETCH;
        retire  = 1'b1;
      end
      BEQ: begin
        state_d = FETCH;
        retire  = 1'b1;
      end
      TRAP: begin
        if (!HALT_ON_ILLEGAL) state_d = FETCH;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // Counter increment, wrapping modulo 2^CNT_W
  always_comb begin
    instret_d = instret_q;
    if (retire) instret_d = instret_q + CNT_W'(1);
  end

  // Moore output decode. The strobe gating at the end keeps every write and
  // request quiet while reset is held, whatever state was current.
  always_comb begin
    pcwrite_o  = 1'b0;
    irwrite_o  = 1'b0;
    iord_o     = 1'b0;
    memread_o  = 1'b0;
    memwrite_o = 1'b0;
    regwrite_o = 1'b0;
    memtoreg_o = 1'b0;
    alusrca_o  = SRCA_PC;
    alusrcb_o  = SRCB_RS2;
    aluop_o    = ALU_ADD;
    branch_o   = 1'b0;
    illegal_o  = 1'b0;
    unique case (state_q)
      FETCH: begin
        memread_o = 1'b1;
        alusrca_o = SRCA_PC;
        alusrcb_o = SRCB_FOUR;
        aluop_o   = ALU_ADD;
        // PC and IR load only once the fetch data is valid
        pcwrite_o = mem_ready_i;
        irwrite_o = mem_ready_i;
      end
      DECODE: begin
        // Branch target precomputed from the old PC while decoding
        alusrca_o = SRCA_OLDPC;
        alusrcb_o = SRCB_IMM;
        aluop_o   = ALU_ADD;
      end
      MEMADR: begin
        alusrca_o = SRCA_RS1;
        alusrcb_o = SRCB_IMM;
        aluop_o   = ALU_ADD;
      end
      MEMRD: begin
        memread_o = 1'b1;
        iord_o    = 1'b1;
      end
      MEMWB: begin
        regwrite_o = 1'b1;
        memtoreg_o = 1'b1;
      end
      MEMWR: begin
        memwrite_o = 1'b1;
        iord_o     = 1'b1;
      end
      EXECR: begin
        alusrca_o = SRCA_RS1;
        alusrcb_o = SRCB_RS2;
        aluop_o   = ALU_FUNCT;
      end
      EXECI: begin
        alusrca_o = SRCA_RS1;
        alusrcb_o = SRCB_IMM;
        aluop_o   = ALU_FUNCT;
      end
      ALUWB: begin
        regwrite_o = 1'b1;
        memtoreg_o = 1'b0;
      end
      BEQ: begin
        alusrca_o = SRCA_RS1;
        alusrcb_o = SRCB_RS2;
        aluop_o   = ALU_SUB;
        branch_o  = 1'b1;
      end
      TRAP: begin
        illegal_o = 1'b1;
      end
      default: begin
        illegal_o = 1'b0;
      end
    endcase
    if (rst_i) begin
      pcwrite_o  = 1'b0;
      irwrite_o  = 1'b0;
      memread_o  = 1'b0;
      memwrite_o = 1'b0;
      regwrite_o = 1'b0;
      branch_o   = 1'b0;
    end
  end

  assign instret_o = instret_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control_unit
//
// Self-checking bench for multicycle_control_unit. Instance A uses the default
// parameters. Instance B uses ENABLE_ITYPE=0, HALT_ON_ILLEGAL=0 and CNT_W=4.
// Both instances share one set of inputs, and each phase checks only its own
// instance. applyStimulus expands an instruction into per-cycle queue entries
// that hold the inputs to drive and the outputs expected from the state
// sequence. runQueue pops the entries, drives them and compares the outputs.
// -----------------------------------------------------------------------------
module tb_multicycle_control_unit;

  localparam logic [6:0] OP_LOAD    = 7'b0000011;
  localparam logic [6:0] OP_STORE   = 7'b0100011;
  localparam logic [6:0] OP_REG     = 7'b0110011;
  localparam logic [6:0] OP_IMM     = 7'b0010011;
  localparam logic [6:0] OP_BRANCH  = 7'b1100011;
  localparam logic [6:0] OP_ILLEGAL = 7'b0101010;

  // Output bundle bit order:
  //   pcwrite irwrite iord memread memwrite regwrite memtoreg
  //   alusrca[1:0] alusrcb[1:0] aluop[1:0] branch illegal
  localparam logic [14:0] E_FETCH_WAIT = 15'b0_0_0_1_0_0_0_00_01_00_0_0;
  localparam logic [14:0] E_FETCH_GO   = 15'b1_1_0_1_0_0_0_00_01_00_0_0;
  localparam logic [14:0] E_DECODE     = 15'b0_0_0_0_0_0_0_10_10_00_0_0;
  localparam logic [14:0] E_MEMADR     = 15'b0_0_0_0_0_0_0_01_10_00_0_0;
  localparam logic [14:0] E_MEMRD      = 15'b0_0_1_1_0_0_0_00_00_00_0_0;
  localparam logic [14:0] E_MEMWB      = 15'b0_0_0_0_0_1_1_00_00_00_0_0;
  localparam logic [14:0] E_MEMWR      = 15'b0_0_1_0_1_0_0_00_00_00_0_0;
  localparam logic [14:0] E_EXECR      = 15'b0_0_0_0_0_0_0_01_00_10_0_0;
  localparam logic [14:0] E_EXECI      = 15'b0_0_0_0_0_0_0_01_10_10_0_0;
  localparam logic [14:0] E_ALUWB      = 15'b0_0_0_0_0_1_0_00_00_00_0_0;
  localparam logic [14:0] E_BEQ        = 15'b0_0_0_0_0_0_0_01_00_01_1_0;
  localparam logic [14:0] E_TRAP       = 15'b0_0_0_0_0_0_0_00_00_00_0_1;
  localparam logic [14:0] FULL_MASK    = 15'h7fff;
  // Only the strobes have required values while reset is held
  localparam logic [14:0] STROBE_MASK  = 15'b1_1_0_1_1_1_0_00_00_00_1_0;

  typedef enum int {
    N_RESET, N_FETCH, N_DECODE, N_MEMADR, N_MEMRD, N_MEMWB, N_MEMWR,
    N_EXECR, N_EXECI, N_ALUWB, N_BEQ, N_TRAP
  } stepName_t;

  typedef struct {
    bit          target;
    bit          rst;
    bit          ready;
    logic [6:0]  opcode;
    logic [14:0] expOut;
    logic [14:0] mask;
    bit          checkCnt;
    int          expCnt;
    stepName_t   name;
  } cycleItem_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        memReady = 1'b0;
  logic [6:0]  instr = 7'd0;
  logic [14:0] outA, outB;
  logic [31:0] instretA;
  logic [3:0]  instretB;

  cycleItem_t  cycleQ[$];
  bit          curTarget = 1'b0;
  int          modelCount = 0;
  int          totalChecks = 0;
  int          badChecks = 0;
  int          itemIdx = 0;

  always #5 clk = ~clk;

  multicycle_control_unit dutA (
    .clk_i         (clk),
    .rst_i         (rst),
    .instruction_i (instr),
    .mem_ready_i   (memReady),
    .pcwrite_o     (outA[14]),
    .irwrite_o     (outA[13]),
    .iord_o        (outA[12]),
    .memread_o     (outA[11]),
    .memwrite_o    (outA[10]),
    .regwrite_o    (outA[9]),
    .memtoreg_o    (outA[8]),
    .alusrca_o     (outA[7:6]),
    .alusrcb_o     (outA[5:4]),
    .aluop_o       (outA[3:2]),
    .branch_o      (outA[1]),
    .illegal_o     (outA[0]),
    .instret_o     (instretA)
  );

  multicycle_control_unit #(
    .ENABLE_ITYPE    (1'b0),
    .HALT_ON_ILLEGAL (1'b0),
    .CNT_W           (4)
  ) dutB (
    .clk_i         (clk),
    .rst_i         (rst),
    .instruction_i (instr),
    .mem_ready_i   (memReady),
    .pcwrite_o     (outB[14]),
    .irwrite_o     (outB[13]),
    .iord_o        (outB[12]),
    .memread_o     (outB[11]),
    .memwrite_o    (outB[10]),
    .regwrite_o    (outB[9]),
    .memtoreg_o    (outB[8]),
    .alusrca_o     (outB[7:6]),
    .alusrcb_o     (outB[5:4]),
    .aluop_o       (outB[3:2]),
    .branch_o      (outB[1]),
    .illegal_o     (outB[0]),
    .instret_o     (instretB)
  );

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [6:0] randOpcode();
    logic [31:0] r;
    r = $urandom;
    return r[6:0];
  endfunction

  function automatic bit randBit();
    logic [31:0] r;
    r = $urandom;
    return r[0];
  endfunction

  // Queue one cycle. Its expected count is the model count at that point.
  task automatic pushItem(input bit rstIn, input bit readyIn, input logic [6:0] opIn,
                          input logic [14:0] expOut, input logic [14:0] mask,
                          input stepName_t name);
    cycleItem_t it;
    it.target   = curTarget;
    it.rst      = rstIn;
    it.ready    = readyIn;
    it.opcode   = opIn;
    it.expOut   = expOut;
    it.mask     = mask;
    it.checkCnt = !rstIn;
    it.expCnt   = curTarget ? (modelCount % 16) : modelCount;
    it.name     = name;
    cycleQ.push_back(it);
  endtask

  // One reset cycle. The count reads zero from the following cycle on.
  task automatic applyReset(input bit readyIn);
    pushItem(1'b1, readyIn, randOpcode(), 15'd0, STROBE_MASK, N_RESET);
    modelCount = 0;
  endtask

  // Expand one instruction into its expected per-cycle behaviour. fetchWait
  // and memWait give the not-ready cycles in FETCH and in MEMRD/MEMWR.
  task automatic applyStimulus(input logic [6:0] op, input int fetchWait,
                               input int memWait);
    bit itypeOn;
    bit haltOn;
    itypeOn = (curTarget == 1'b0);
    haltOn  = (curTarget == 1'b0);
    for (int i = 0; i < fetchWait; i++)
      pushItem(1'b0, 1'b0, randOpcode(), E_FETCH_WAIT, FULL_MASK, N_FETCH);
    pushItem(1'b0, 1'b1, randOpcode(), E_FETCH_GO, FULL_MASK, N_FETCH);
    pushItem(1'b0, randBit(), op, E_DECODE, FULL_MASK, N_DECODE);
    if (op == OP_LOAD) begin
      pushItem(1'b0, randBit(), op, E_MEMADR, FULL_MASK, N_MEMADR);
      for (int i = 0; i < memWait; i++)
        pushItem(1'b0, 1'b0, randOpcode(), E_MEMRD, FULL_MASK, N_MEMRD);
      pushItem(1'b0, 1'b1, randOpcode(), E_MEMRD, FULL_MASK, N_MEMRD);
      pushItem(1'b0, randBit(), randOpcode(), E_MEMWB, FULL_MASK, N_MEMWB);
      modelCount++;
    end else if (op == OP_STORE) begin
      pushItem(1'b0, randBit(), op, E_MEMADR, FULL_MASK, N_MEMADR);
      for (int i = 0; i < memWait; i++)
        pushItem(1'b0, 1'b0, randOpcode(), E_MEMWR, FULL_MASK, N_MEMWR);
      pushItem(1'b0, 1'b1, randOpcode(), E_MEMWR, FULL_MASK, N_MEMWR);
      modelCount++;
    end else if (op == OP_REG) begin
      pushItem(1'b0, randBit(), randOpcode(), E_EXECR, FULL_MASK, N_EXECR);
      pushItem(1'b0, randBit(), randOpcode(), E_ALUWB, FULL_MASK, N_ALUWB);
      modelCount++;
    end else if (op == OP_IMM && itypeOn) begin
      pushItem(1'b0, randBit(), randOpcode(), E_EXECI, FULL_MASK, N_EXECI);
      pushItem(1'b0, randBit(), randOpcode(), E_ALUWB, FULL_MASK, N_ALUWB);
      modelCount++;
    end else if (op == OP_BRANCH) begin
      pushItem(1'b0, randBit(), randOpcode(), E_BEQ, FULL_MASK, N_BEQ);
      modelCount++;
    end else if (haltOn) begin
      for (int i = 0; i < 12; i++)
        pushItem(1'b0, randBit(), randOpcode(), E_TRAP, FULL_MASK, N_TRAP);
    end else begin
      pushItem(1'b0, randBit(), randOpcode(), E_TRAP, FULL_MASK, N_TRAP);
    end
  endtask

  // Drive each queued cycle just after the rising edge. Compare the outputs
  // on the falling edge.
  task automatic runQueue();
    cycleItem_t it;
    logic [14:0] obs;
    logic [31:0] cnt;
    while (cycleQ.size() > 0) begin
      it = cycleQ.pop_front();
      @(posedge clk);
      #1;
      rst      = it.rst;
      memReady = it.ready;
      instr    = it.opcode;
      @(negedge clk);
      obs = it.target ? outB : outA;
      cnt = it.target ? {28'd0, instretB} : instretA;
      checkOutput($sformatf("%s#%0d_%s_out", it.target ? "B" : "A", itemIdx, it.name.name()),
                  {17'd0, obs & it.mask}, {17'd0, it.expOut & it.mask});
      if (it.checkCnt)
        checkOutput($sformatf("%s#%0d_%s_instret", it.target ? "B" : "A", itemIdx, it.name.name()),
                    cnt, it.expCnt);
      itemIdx++;
    end
  endtask

  initial begin
    logic [6:0] ops [5];
    logic [31:0] r;
    ops[0] = OP_LOAD;
    ops[1] = OP_STORE;
    ops[2] = OP_REG;
    ops[3] = OP_IMM;
    ops[4] = OP_BRANCH;

    // Instance A, default parameters
    curTarget = 1'b0;
    applyReset(1'b1);
    applyReset(1'b0);
    applyStimulus(OP_REG, 0, 0);
    applyStimulus(OP_LOAD, 0, 2);
    applyStimulus(OP_STORE, 0, 0);
    applyStimulus(OP_BRANCH, 0, 0);
    applyStimulus(OP_IMM, 0, 0);
    applyStimulus(OP_REG, 2, 0);
    applyStimulus(OP_STORE, 1, 3);
    for (int i = 0; i < 10; i++) begin
      r = $urandom_range(0, 4);
      applyStimulus(ops[r], $urandom_range(0, 2), $urandom_range(0, 2));
    end
    // Reset lands in MEMWR with ready high; no write may leak out
    pushItem(1'b0, 1'b1, randOpcode(), E_FETCH_GO, FULL_MASK, N_FETCH);
    pushItem(1'b0, 1'b0, OP_STORE, E_DECODE, FULL_MASK, N_DECODE);
    pushItem(1'b0, 1'b0, OP_STORE, E_MEMADR, FULL_MASK, N_MEMADR);
    pushItem(1'b0, 1'b0, randOpcode(), E_MEMWR, FULL_MASK, N_MEMWR);
    applyReset(1'b1);
    applyStimulus(OP_REG, 0, 0);
    // Illegal opcode holds TRAP until reset
    applyStimulus(OP_ILLEGAL, 0, 0);
    applyReset(1'b0);
    applyStimulus(OP_LOAD, 0, 0);
    runQueue();

    // Instance B: no I-type, one-cycle trap, 4-bit counter
    curTarget = 1'b1;
    applyReset(1'b0);
    applyStimulus(OP_IMM, 0, 0);
    applyStimulus(OP_LOAD, 1, 1);
    applyStimulus(OP_ILLEGAL, 0, 0);
    applyStimulus(OP_LOAD, 0, 0);
    applyReset(1'b0);
    for (int i = 0; i < 17; i++)
      applyStimulus(OP_REG, 0, 0);
    applyStimulus(OP_BRANCH, 0, 0);
    runQueue();

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Multi-cycle control FSM for the RISC-V datapath, successor to the single-cycle combinational `control_unit`. It sequences each instruction through fetch, decode, execute, memory and writeback states, and stalls on a memory-ready handshake. Per-state datapath strobes and mux selects are driven from a registered state. The block adds optional I-type ALU support, a configurable illegal-opcode policy and a retired-instruction counter. It sits between the instruction register opcode field and the shared-memory multicycle datapath.

## Interface
- `ENABLE_ITYPE`, default 1: decode opcode 7'b0010011 (OP-IMM) when 1; treat it as illegal when 0.
- `HALT_ON_ILLEGAL`, default 1: when 1, an illegal opcode parks the FSM in TRAP until reset; when 0, TRAP lasts one cycle and then returns to FETCH.
- `CNT_W`, default 32: width of the retired-instruction counter.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `instruction` in 7: opcode field `ir[6:0]`; sampled only in DECODE, MEMADR and TRAP entry.
- `mem_ready` in 1: memory has completed the current access.
- `pcwrite`, `irwrite` out 1 each: load PC and load IR.
- `iord` out 1: memory address source (0 = PC, 1 = ALU result register).
- `memread`, `memwrite` out 1 each: memory request strobes.
- `regwrite` out 1: register file write enable.
- `memtoreg` out 1: writeback source (1 = memory data register).
- `alusrca` out 2: ALU A select (00 = PC, 01 = rs1, 10 = oldPC).
- `alusrcb` out 2: ALU B select (00 = rs2, 01 = const 4, 10 = immediate).
- `aluop` out 2: 00 = add, 01 = subtract/compare, 10 = funct decode.
- `branch` out 1: PC load if ALU zero.
- `illegal` out 1: high in TRAP.
- `instret` out CNT_W: retired-instruction count.

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BEQ, TRAP. Outputs are a Moore decode of the state. Any output not listed for a state is 0.
- FETCH: memread=1, iord=0, alusrca=00, alusrcb=01, aluop=00, pcwrite=irwrite=`mem_ready`. Stay while `mem_ready`=0; go to DECODE when it is 1.
- DECODE: alusrca=10, alusrcb=10, aluop=00 (precomputes the branch target). Next state by opcode:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECR
  - 1100011 → BEQ
  - 0010011 → EXECI if ENABLE_ITYPE
  - any other opcode → TRAP
- MEMADR: alusrca=01, alusrcb=10, aluop=00. Go to MEMRD if opcode is 0000011, otherwise MEMWR.
- MEMRD: memread=1, iord=1. Wait for `mem_ready`, then go to MEMWB.
- MEMWB: regwrite=1, memtoreg=1. Go to FETCH.
- MEMWR: memwrite=1, iord=1. Wait for `mem_ready`, then go to FETCH.
- EXECR: alusrca=01, alusrcb=00, aluop=10. Go to ALUWB.
- EXECI: alusrca=01, alusrcb=10, aluop=10. Go to ALUWB.
- ALUWB: regwrite=1, memtoreg=0. Go to FETCH.
- BEQ: alusrca=01, alusrcb=00, aluop=01, branch=1. Go to FETCH.
- TRAP: illegal=1. Behaviour depends on HALT_ON_ILLEGAL:
  - HALT_ON_ILLEGAL=1: hold TRAP until `rst`.
  - HALT_ON_ILLEGAL=0: go to FETCH on the next edge.
- `instret` increments by 1 on the edge that leaves MEMWB, ALUWB or BEQ, and on the edge that leaves MEMWR with `mem_ready`=1.
  - TRAP never retires.
  - The counter wraps modulo 2^CNT_W with no flag.

## Timing
- Reset:
  - On the `rst` edge, state becomes FETCH and `instret` becomes 0.
  - While `rst`=1, pcwrite, irwrite, memread, memwrite, regwrite and branch are forced to 0 regardless of state.
  - After reset is released, outputs take FETCH values.
- Reset mid-operation (including in MEMWR or TRAP) takes priority over every transition. No write strobe is asserted in the cycle `rst` is high.
- Latency with `mem_ready` tied high:
  - LW: 5 cycles
  - SW: 4 cycles
  - R-type and I-type: 4 cycles
  - BEQ: 3 cycles
  - Each cycle with `mem_ready`=0 in FETCH, MEMRD or MEMWR adds one cycle.
- `mem_ready` is ignored outside FETCH, MEMRD and MEMWR. A ready pulse in any other state has no effect.
- pcwrite and irwrite assert only in the FETCH cycle that also sees `mem_ready`=1, exactly once per instruction.
- Opcode changes outside DECODE and MEMADR have no effect on the sequence.

## Test plan
- Reset then R-type 0110011 with `mem_ready`=1: states FETCH→DECODE→EXECR→ALUWB→FETCH; regwrite=1 only in cycle 4; `instret`=1 after cycle 4.
- LW 0000011 with `mem_ready` low for 2 cycles in MEMRD: 7 cycles total; memread=1 and iord=1 for 3 cycles; then MEMWB with memtoreg=1 and regwrite=1.
- SW 0100011 followed by BEQ 1100011: memwrite=1 for exactly 1 cycle; branch=1 with aluop=01 in BEQ; `instret`=2 after 7 cycles.
- Illegal opcode 0101010 with HALT_ON_ILLEGAL=1: `illegal` stays 1 for 10 or more cycles and `instret` does not change; `rst` then returns the FSM to FETCH with `instret`=0. With HALT_ON_ILLEGAL=0, `illegal` pulses for 1 cycle, the FSM refetches, and a following LW completes.
- ENABLE_ITYPE=0 with opcode 0010011 goes to TRAP; ENABLE_ITYPE=1 gives FETCH→DECODE→EXECI (alusrcb=10, aluop=10)→ALUWB.
- CNT_W=4: retire 17 R-type instructions; `instret` reads 1 (wrapped). Assert `rst` during MEMWR: memwrite=0 in that cycle and state is FETCH on the next edge.
